// File: rtl/prod_window_sum.sv
// prod_window_sum: sliding-window sum of the last 2^WINDOW_LOG2 complex products
module prod_window_sum #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW_LOG2 = 4,
  localparam int SUM_WIDTH = DATA_WIDTH + WINDOW_LOG2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] prod_i,
  input  logic [DATA_WIDTH-1:0] prod_q,
  input  logic                  prod_strobe,
  output logic [SUM_WIDTH-1:0]  sum_i,
  output logic [SUM_WIDTH-1:0]  sum_q,
  output logic                  sum_strobe,
  output logic                  window_full
);
  localparam int N = 1 << WINDOW_LOG2;
  logic [2*DATA_WIDTH-1:0] mem [N];
  logic [WINDOW_LOG2-1:0]  wr_ptr;
  logic [WINDOW_LOG2:0]    fill_cnt;
  logic                    accept;
  logic [2*DATA_WIDTH-1:0] old;
  logic [SUM_WIDTH-1:0]    add_i, add_q, sub_i, sub_q;
  assign accept = enable & prod_strobe;
  // fill_cnt saturates at exactly N, so its top bit means the window is full
  assign window_full = fill_cnt[WINDOW_LOG2];
  assign old = window_full ? mem[wr_ptr] : '0;
  assign add_i = {{WINDOW_LOG2{prod_i[DATA_WIDTH-1]}}, prod_i};
  assign add_q = {{WINDOW_LOG2{prod_q[DATA_WIDTH-1]}}, prod_q};
  assign sub_i = {{WINDOW_LOG2{old[DATA_WIDTH-1]}}, old[DATA_WIDTH-1:0]};
  assign sub_q = {{WINDOW_LOG2{old[2*DATA_WIDTH-1]}}, old[2*DATA_WIDTH-1:DATA_WIDTH]};
  always_ff @(posedge clock)
    if (accept && !reset) mem[wr_ptr] <= {prod_q, prod_i};
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_i <= '0;
      sum_q <= '0;
      sum_strobe <= 1'b0;
      wr_ptr <= '0;
      fill_cnt <= '0;
    end else begin
      sum_strobe <= accept;
      if (accept) begin
        sum_i <= sum_i + add_i - sub_i;
        sum_q <= sum_q + add_q - sub_q;
        wr_ptr <= wr_ptr + 1'b1;
        fill_cnt <= window_full ? fill_cnt : fill_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prod_window_sum.sv
// tb_prod_window_sum: randomized scoreboard bench against a queue-based window-sum model
module tb_prod_window_sum;
  logic clock = 0, reset = 0, enable = 0, prod_strobe = 0;
  logic [31:0] prod_i = 0, prod_q = 0;
  logic [35:0] sum_i, sum_q;
  logic sum_strobe, window_full;

  prod_window_sum dut (
    .clock(clock), .reset(reset), .enable(enable),
    .prod_i(prod_i), .prod_q(prod_q), .prod_strobe(prod_strobe),
    .sum_i(sum_i), .sum_q(sum_q), .sum_strobe(sum_strobe), .window_full(window_full)
  );

  always #5 clock = ~clock;

  typedef struct {int due; logic [35:0] si; logic [35:0] sq; logic full;} exp_t;
  exp_t exp_q[$];
  longint hist_i[$], hist_q[$];
  int accepted = 0, cyc = 0, checks = 0, failures = 0;
  logic [35:0] hold_i = 0, hold_q = 0;
  logic hold_full = 0, chk_hold = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", n, act, req, cyc);
    end
  endtask

  // Reference: sum of the most recent min(accepted,16) samples since reset
  task automatic drive(input logic en, input logic stb, input int pi, input int pq);
    exp_t e;
    longint si = 0, sq = 0;
    enable = en; prod_strobe = stb; prod_i = pi; prod_q = pq;
    if (en && stb) begin
      hist_i.push_back(longint'(pi));
      hist_q.push_back(longint'(pq));
      if (hist_i.size() > 16) begin
        void'(hist_i.pop_front());
        void'(hist_q.pop_front());
      end
      foreach (hist_i[k]) begin
        si += hist_i[k];
        sq += hist_q[k];
      end
      accepted++;
      e.due = cyc + 1; e.si = 36'(si); e.sq = 36'(sq); e.full = accepted >= 16;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    for (int k = 0; k < n; k++) begin
      enable = 1; prod_strobe = 1; prod_i = $urandom; prod_q = $urandom;
      @(posedge clock); #1;
      hold_i = 0; hold_q = 0; hold_full = 0; chk_hold = 1;
      hist_i.delete(); hist_q.delete(); accepted = 0;
    end
    reset = 0; prod_strobe = 0;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clock);
    if (sum_strobe === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_strobe", 64'(sum_strobe), 0);
      else begin
        e = exp_q.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("sum_i", 64'(sum_i), 64'(e.si));
        chk("sum_q", 64'(sum_q), 64'(e.sq));
        chk("window_full", 64'(window_full), 64'(e.full));
        hold_i = e.si; hold_q = e.sq; hold_full = e.full;
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      chk("missing_strobe", 64'(sum_strobe), 1);
      void'(exp_q.pop_front());
    end else if (chk_hold) begin
      chk("strobe_idle", 64'(sum_strobe), 0);
      chk("hold_i", 64'(sum_i), 64'(hold_i));
      chk("hold_q", 64'(sum_q), 64'(hold_q));
      chk("hold_full", 64'(window_full), 64'(hold_full));
    end
  end

  initial begin
    @(posedge clock); #1;
    do_reset(3);
    drive(1, 1, 5, 2);
    repeat (3) drive(1, 0, 0, 0);
    do_reset(1);
    repeat (40) drive(1, 1, 100, -3);
    do_reset(1);
    for (int k = 1; k <= 40; k++) drive(1, 1, k, -k);
    do_reset(1);
    repeat (20) drive(1, 1, int'(32'h8000_0000), int'(32'h7fff_ffff));
    do_reset(1);
    for (int k = 0; k < 90; k++) begin
      if (k >= 40 && k < 45) drive(0, (k == 41 || k == 44), $urandom, $urandom);
      else drive(1, (k % 3 == 0), $urandom, $urandom);
    end
    for (int k = 0; k < 300; k++)
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom);
    do_reset(1);
    repeat (10) drive(1, 1, 7, 7);
    do_reset(1);
    repeat (16) drive(1, 1, 1, 0);
    repeat (4) drive(1, 0, 0, 0);
    chk("pending_expected", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
